// File: rtl/cpu_lsu.sv
// Load/store unit: request/grant/response data-memory transaction with lane placement and load extension.
// Optional feature macro: CPU_LSU_MISALIGN_TRAP_EN (reject misaligned ops instead of forcing alignment).
module cpu_lsu #(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic              ex_mem_wr_en,
    input  logic [3:0]        ex_byt_en,
    input  logic              ex_sign_ext,
    input  logic [RD_W-1:0]   ex_rd,
    output logic              dmem_req,
    input  logic              dmem_gnt,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              done,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              misalign
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        be_reg;
    logic [3:0]        size_reg;
    logic [31:0]       wdata_reg;
    logic              we_reg;
    logic [1:0]        off_reg;
    logic              sign_reg;
    logic [RD_W-1:0]   rd_reg;
    logic              done_reg;
    logic              wb_valid_reg;
    logic [31:0]       wb_data_reg;
    logic [RD_W-1:0]   wb_rd_reg;

    logic              accept;
    logic              is_half;
    logic              is_word;
    logic              mis_op;
    logic [1:0]        off_eff;
    logic              latch_op;
    logic              reject;
    logic              op_done;
    logic              load_done;
    logic [31:0]       rdata_shifted;
    logic              fill_bit;
    logic [31:0]       load_ext;

    assign accept  = ex_valid && ex_ready;
    assign is_half = (ex_byt_en == 4'b0011);
    assign is_word = (ex_byt_en == 4'b1111);

`ifdef CPU_LSU_MISALIGN_TRAP_EN
    assign mis_op  = (is_half && ex_addr[0]) || (is_word && (ex_addr[1:0] != 2'b00));
    assign off_eff = ex_addr[1:0];
`else
    // Misaligned ops are snapped down to the natural boundary of their size.
    assign mis_op  = 1'b0;
    assign off_eff = is_word ? 2'b00 : (is_half ? {ex_addr[1], 1'b0} : ex_addr[1:0]);
`endif

    always_comb begin
        state_next = state_reg;
        latch_op   = 1'b0;
        reject     = 1'b0;
        op_done    = 1'b0;
        load_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (mis_op) begin
                        reject = 1'b1;
                    end else begin
                        latch_op   = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (we_reg) begin
                        op_done    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    op_done    = 1'b1;
                    load_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg     <= '0;
            be_reg       <= '0;
            size_reg     <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            off_reg      <= '0;
            sign_reg     <= 1'b0;
            rd_reg       <= '0;
            done_reg     <= 1'b0;
            wb_valid_reg <= 1'b0;
            wb_data_reg  <= '0;
            wb_rd_reg    <= '0;
        end else begin
            if (latch_op) begin
                addr_reg  <= {ex_addr[ADDR_W-1:2], 2'b00};
                be_reg    <= ex_byt_en << off_eff;
                size_reg  <= ex_byt_en;
                wdata_reg <= ex_wdata << {off_eff, 3'b000};
                we_reg    <= ex_mem_wr_en;
                off_reg   <= off_eff;
                sign_reg  <= ex_sign_ext;
                rd_reg    <= ex_rd;
            end
            done_reg     <= op_done || reject;
            wb_valid_reg <= load_done;
            if (load_done) begin
                wb_data_reg <= load_ext;
                wb_rd_reg   <= rd_reg;
            end
        end
    end

    // Bring the addressed lane(s) down to bit 0, then fill bytes above the access size.
    assign rdata_shifted = dmem_rdata >> {off_reg, 3'b000};
    assign fill_bit      = sign_reg && (size_reg[1] ? rdata_shifted[15] : rdata_shifted[7]);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign load_ext[8*gi +: 8] = size_reg[gi] ? rdata_shifted[8*gi +: 8] : {8{fill_bit}};
        end
    endgenerate

`ifdef CPU_LSU_MISALIGN_TRAP_EN
    logic misalign_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= reject;
        end
    end

    assign misalign = misalign_reg;
`else
    assign misalign = 1'b0;
`endif

    assign ex_ready   = (state_reg == IDLE);
    assign dmem_req   = (state_reg == REQ);
    assign dmem_we    = (state_reg == REQ) && we_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_be    = be_reg;
    assign dmem_wdata = wdata_reg;
    assign done       = done_reg;
    assign wb_valid   = wb_valid_reg;
    assign wb_data    = wb_data_reg;
    assign wb_rd      = wb_rd_reg;

endmodule

// File: tb/tb_cpu_lsu.sv
// Self-checking bench for cpu_lsu: directed test-plan steps plus random ops against an arithmetic model.
module tb_cpu_lsu;

    localparam int ADDR_W = 32;
    localparam int RD_W   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_addr;
    logic [31:0]       ex_wdata;
    logic              ex_mem_wr_en;
    logic [3:0]        ex_byt_en;
    logic              ex_sign_ext;
    logic [RD_W-1:0]   ex_rd;
    logic              dmem_req;
    logic              dmem_gnt;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_rvalid;
    logic [31:0]       dmem_rdata;
    logic              done;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              misalign;

    int errors = 0;
    int checks = 0;

    cpu_lsu #(.ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_mem_wr_en(ex_mem_wr_en), .ex_byt_en(ex_byt_en), .ex_sign_ext(ex_sign_ext), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .done(done), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction; all driving and sampling happens on the falling edge.
    task automatic do_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int size, input bit sgn, input logic [4:0] rd,
                         input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
        int           off;
        bit           mis;
        logic [31:0]  exp_addr, exp_wdata, exp_data;
        logic [3:0]   exp_be;
        longint unsigned v;

        mis = (addr % size) != 0;
`ifdef CPU_LSU_MISALIGN_TRAP_EN
        off = addr % 4;
`else
        off = (addr - (addr % size)) % 4;
        mis = 1'b0;
`endif
        exp_addr  = addr - (addr % 4);
        exp_be    = 4'(((1 << size) - 1) << off);
        exp_wdata = 32'((64'(wdata) * (64'd1 << (8 * off))) % (64'd1 << 32));
        v = (64'(rdata) >> (8 * off)) % (64'd1 << (8 * size));
        if (sgn && size < 4 && v >= (64'd1 << (8 * size - 1)))
            v = v + (64'd1 << 32) - (64'd1 << (8 * size));
        exp_data = v[31:0];

        check("ex_ready_accept", {31'b0, ex_ready}, 32'd1);
        ex_valid     = 1'b1;
        ex_addr      = addr;
        ex_wdata     = wdata;
        ex_mem_wr_en = we;
        ex_byt_en    = 4'((1 << size) - 1);
        ex_sign_ext  = sgn;
        ex_rd        = rd;
        @(negedge clk);
        ex_valid = 1'b0;
        ex_addr  = $urandom;
        ex_wdata = $urandom;

        if (mis) begin
            check("mis_misalign", {31'b0, misalign}, 32'd1);
            check("mis_done", {31'b0, done}, 32'd1);
            check("mis_wb_valid", {31'b0, wb_valid}, 32'd0);
            check("mis_req", {31'b0, dmem_req}, 32'd0);
            $display("op we=%0d addr=0x%08h size=%0d misaligned rejected", we, addr, size);
            return;
        end

        for (int i = 0; i <= gnt_wait; i++) begin
            check("req", {31'b0, dmem_req}, 32'd1);
            check("req_we", {31'b0, dmem_we}, {31'b0, we});
            check("req_addr", dmem_addr, exp_addr);
            check("req_be", {28'b0, dmem_be}, {28'b0, exp_be});
            if (we) check("req_wdata", dmem_wdata, exp_wdata);
            check("req_done", {31'b0, done}, 32'd0);
            dmem_gnt = (i == gnt_wait);
            @(negedge clk);
        end
        dmem_gnt = 1'b0;

        if (!we) begin
            for (int i = 0; i <= rv_wait; i++) begin
                check("resp_req", {31'b0, dmem_req}, 32'd0);
                check("resp_done", {31'b0, done}, 32'd0);
                dmem_rvalid = (i == rv_wait);
                dmem_rdata  = (i == rv_wait) ? rdata : 32'($urandom);
                @(negedge clk);
            end
            dmem_rvalid = 1'b0;
            check("ld_done", {31'b0, done}, 32'd1);
            check("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
            check("ld_wb_data", wb_data, exp_data);
            check("ld_wb_rd", {27'b0, wb_rd}, {27'b0, rd});
        end else begin
            check("st_done", {31'b0, done}, 32'd1);
            check("st_wb_valid", {31'b0, wb_valid}, 32'd0);
        end
        check("misalign_low", {31'b0, misalign}, 32'd0);
        $display("op we=%0d addr=0x%08h size=%0d sign=%0d rd=%0d wdata=0x%08h rdata=0x%08h exp=0x%08h",
                 we, addr, size, sgn, rd, wdata, rdata, we ? exp_wdata : exp_data);
    endtask

    initial begin
        int sz, sizes[3];
        sizes = '{1, 2, 4};
        rst = 1'b1; ex_valid = 1'b0; ex_addr = '0; ex_wdata = '0; ex_mem_wr_en = 1'b0;
        ex_byt_en = 4'b0001; ex_sign_ext = 1'b0; ex_rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_we", {31'b0, dmem_we}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", {28'b0, dmem_be}, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        rst = 1'b0;

        do_op(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4, 1'b0, 5'd0, 0, 0, 32'h0);
        do_op(1'b0, 32'h0000_2003, 32'h0, 1, 1'b1, 5'd7, 0, 0, 32'h8000_0000);
        do_op(1'b0, 32'h0000_2003, 32'h0, 1, 1'b0, 5'd9, 0, 0, 32'h8000_0000);
        do_op(1'b1, 32'h0000_0012, 32'h0000_ABCD, 2, 1'b0, 5'd0, 3, 0, 32'h0);
        do_op(1'b0, 32'h0000_2002, 32'h0, 4, 1'b1, 5'd3, 1, 2, 32'h1234_5678);
        do_op(1'b0, 32'h0000_3006, 32'h0, 2, 1'b1, 5'd12, 0, 1, 32'h9ABC_0000);

        for (int n = 0; n < 40; n++) begin
            sz = sizes[$urandom_range(0, 2)];
            do_op(1'($urandom), $urandom, $urandom, sz, 1'($urandom), 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // Abort a load in RESP with reset; a late rvalid must be dropped.
        check("abort_ready", {31'b0, ex_ready}, 32'd1);
        ex_valid = 1'b1; ex_addr = 32'h0000_4000; ex_mem_wr_en = 1'b0; ex_byt_en = 4'b1111; ex_rd = 5'd5;
        @(negedge clk);
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("abort_in_resp", {31'b0, dmem_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ex_ready", {31'b0, ex_ready}, 32'd1);
        check("abort_req", {31'b0, dmem_req}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_wb_valid", {31'b0, wb_valid}, 32'd0);
        @(negedge clk);
        check("abort_done_late", {31'b0, done}, 32'd0);
        check("abort_wb_late", {31'b0, wb_valid}, 32'd0);
        $display("op reset-abort load addr=0x00004000 dropped");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_lsu.md
# cpu_lsu

Load/store unit sitting directly downstream of the execute stage. It consumes the memory-related fields of the control word (`mem_wr_en`, `mem_byt_en`, `sign_ext`, `sel_dmem_wb`), the ALU result as effective address and rs2 as store data. It runs a request/grant/response transaction on the data-memory bus, then returns aligned, sign- or zero-extended load data tagged with the destination register. It stalls the pipeline through a ready signal while a transaction is in flight.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width on both pipeline and bus side
- `RD_W`, 5, destination register tag width

Ports:
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ex_valid`  in  1  memory op presented
- `ex_ready`  out  1  unit idle and able to accept; handshake completes when `ex_valid && ex_ready`
- `ex_addr`  in  ADDR_W  effective byte address (ALU output)
- `ex_wdata`  in  32  store data, unshifted (rs2)
- `ex_mem_wr_en`  in  1  1 = store, 0 = load
- `ex_byt_en`  in  4  size mask, unshifted: 0001 byte, 0011 half, 1111 word
- `ex_sign_ext`  in  1  sign-extend load result
- `ex_rd`  in  RD_W  load destination tag
- `dmem_req`  out  1  bus request, held until granted
- `dmem_gnt`  in  1  request accepted this cycle
- `dmem_we`  out  1  write strobe
- `dmem_addr`  out  ADDR_W  word-aligned address (`[1:0]` = 0)
- `dmem_be`  out  4  byte lanes, size mask shifted by `addr[1:0]`
- `dmem_wdata`  out  32  store data replicated/shifted onto lanes
- `dmem_rvalid`  in  1  read data valid
- `dmem_rdata`  in  32  read data, word-aligned
- `done`  out  1  one-cycle pulse, op completed
- `wb_valid`  out  1  one-cycle pulse with `done` for loads only
- `wb_data`  out  32  extended load result
- `wb_rd`  out  RD_W  tag of completed load
- `misalign`  out  1  one-cycle pulse, op rejected as misaligned

## Operation
- FSM states: IDLE, REQ, RESP.
  - IDLE: `ex_ready`=1. On handshake, latch the op.
    - Aligned op → REQ.
    - Misaligned op → pulse `misalign` and `done` next cycle, stay IDLE.
  - REQ: `dmem_req`=1, bus outputs stable.
    - On `dmem_gnt`: store → IDLE with `done` next cycle; load → RESP.
  - RESP: wait for `dmem_rvalid`, then → IDLE with `done`/`wb_valid` next cycle.
- Alignment rule:
  - half requires `addr[0]`=0.
  - word requires `addr[1:0]`=0.
  - byte is always aligned.
- Lane placement:
  - `dmem_be = ex_byt_en << addr[1:0]`.
  - `dmem_wdata = ex_wdata << (8*addr[1:0])`.
- Load extraction: `rdata >> (8*addr[1:0])`, masked to the size. If `sign_ext`=1, bit 7 (byte) or bit 15 (half) is replicated up to bit 31; otherwise zero-filled.
- `dmem_rvalid` is ignored outside RESP.
- `ex_byt_en` values other than 0001/0011/1111 are illegal. Behaviour for them is undefined and is not verified.

## Timing
- Reset values: `ex_ready`=1; `dmem_req`, `dmem_we`, `done`, `wb_valid`, `misalign` = 0; `dmem_addr`, `dmem_be`, `dmem_wdata`, `wb_data`, `wb_rd` = 0. State = IDLE.
- Min store latency: accept at cycle 0, `dmem_req` at cycle 1 with gnt, `done` at cycle 2.
- Min load latency: accept at cycle 0, req+gnt at cycle 1, rvalid at cycle 2, `done`/`wb_valid` at cycle 3.
- `dmem_rvalid` is legal at the earliest one cycle after gnt. Same-cycle gnt+rvalid is not supported.
- Back-to-back: next op is accepted in the cycle `done` is high, because `ex_ready` returns to 1 there.
- Misaligned op: `misalign`+`done` at cycle 1 with no bus activity. `wb_valid`=0.
- Reset mid-operation: state returns to IDLE at the edge, and `dmem_req` is 0 in the following cycle. A late `rvalid` arriving afterwards is dropped, and no `done` is generated for the aborted op.

## Configuration
- `CPU_LSU_MISALIGN_TRAP_EN` defined: misaligned ops are rejected as in Operation, and `misalign` pulses.
- Not defined:
  - `misalign` is tied to 0.
  - Misaligned addresses are forced to natural alignment (`addr[0]` cleared for half, `addr[1:0]` cleared for word) and the access proceeds normally.

## Test plan
- Store word, addr 0x1004, data 0xDEADBEEF, gnt immediate → `dmem_addr`=0x1004, `dmem_be`=1111, `done` at cycle 2.
- Load byte signed, addr 0x2003, rdata 0x80000000 → `wb_data`=0xFFFFFF80, `wb_rd`=tag, `wb_valid` at cycle 3. Repeat unsigned → 0x00000080.
- Store half, addr 0x10 with `addr[1]`=1 (0x12), data 0x0000ABCD → `dmem_be`=1100, `dmem_wdata`=0xABCD0000. Hold `dmem_gnt` low 3 cycles → `dmem_req` and bus outputs stable throughout.
- Load word at 0x2002 → with macro: `misalign`+`done` at cycle 1, `dmem_req` never asserted. Without macro: access at 0x2000, `be`=1111.
- Assert `rst` in RESP, then drive `rvalid` → no `done`/`wb_valid`. `ex_ready`=1 the cycle after reset.
